// File: rtl/screen_pkg.sv
// screen_pkg: shared encodings and defaults
// for the screen sequencer slice.
package screen_pkg;

  localparam int SCR_W_D = 160;
  localparam int SCR_H_D = 120;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] WHITE = 3'b111;

  typedef enum logic [2:0] {
    CLR_HOME  = 3'd0,
    DRAW_HOME = 3'd1,
    HOME_IDLE = 3'd2,
    CLR_GAME  = 3'd3,
    RUN       = 3'd4
  } scr_state_t;

  function automatic logic is_clr(scr_state_t s);
    return (s == CLR_HOME) || (s == CLR_GAME);
  endfunction

endpackage

// File: rtl/screen_if.sv
// screen_if: drawer and VGA pixel buses
// around the screen sequencer.
interface screen_if;

  logic [7:0] hs_x;
  logic [6:0] hs_y;
  logic [2:0] hs_col;
  logic       hs_plot;
  logic       hs_done;
  logic       hs_enable;

  logic [7:0] gm_x;
  logic [6:0] gm_y;
  logic [2:0] gm_col;
  logic       gm_plot;
  logic       gm_enable;

  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  modport master (
    input  hs_x, hs_y, hs_col,
    input  hs_plot, hs_done,
    input  gm_x, gm_y, gm_col, gm_plot,
    output hs_enable, gm_enable,
    output vga_x, vga_y,
    output vga_colour, vga_plot
  );

  modport slave (
    output hs_x, hs_y, hs_col,
    output hs_plot, hs_done,
    output gm_x, gm_y, gm_col, gm_plot,
    input  hs_enable, gm_enable,
    input  vga_x, vga_y,
    input  vga_colour, vga_plot
  );

endinterface

// File: rtl/frame_clear_counter.sv
// frame_clear_counter: raster walk over the
// whole frame, raster order, for clearing.
module frame_clear_counter #(
  parameter int W = 160,
  parameter int H = 120
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       run,
  output logic [7:0] cx,
  output logic [6:0] cy,
  output logic       done
);

  logic x_last;

  assign x_last = (cx == 8'(W - 1));
  assign done   = x_last && (cy == 7'(H - 1));

  // Advance cx each run cycle, carry into cy, wrap at frame end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cx <= '0;
      cy <= '0;
    end else if (start) begin
      cx <= '0;
      cy <= '0;
    end else if (run) begin
      if (x_last) begin
        cx <= '0;
        cy <= done ? 7'd0 : cy + 7'd1;
      end else begin
        cx <= cx + 8'd1;
      end
    end
  end

endmodule

// File: rtl/screen_sequencer.sv
// screen_sequencer: clear / homescreen / game
// screen flow with a registered pixel mux.
module screen_sequencer
  import screen_pkg::*;
#(
  parameter int         SCR_W   = SCR_W_D,
  parameter int         SCR_H   = SCR_H_D,
  parameter logic [2:0] CLR_COL = BLACK
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       key_start,
  input  logic       game_over,
  screen_if.master   bus,
  output logic [2:0] state_o
);

  scr_state_t state;
  scr_state_t state_nx;

  logic       key_prev;
  logic       key_rise;

  logic       clr_start;
  logic       clr_run;
  logic       clr_done;
  logic [7:0] cx;
  logic [6:0] cy;

  logic [7:0] x_d;
  logic [6:0] y_d;
  logic [2:0] col_d;
  logic       plot_d;

  logic [7:0] vx;
  logic [6:0] vy;
  logic [2:0] vc;
  logic       vp;
  logic       hs_en;
  logic       gm_en;

  assign key_rise  = key_start && !key_prev;
  assign clr_run   = is_clr(state);
  assign clr_start = !is_clr(state) &&
                     is_clr(state_nx);

  frame_clear_counter #(
    .W (SCR_W),
    .H (SCR_H)
  ) u_clr (
    .clk    (clk),
    .resetn (resetn),
    .start  (clr_start),
    .run    (clr_run),
    .cx     (cx),
    .cy     (cy),
    .done   (clr_done)
  );

  // State, key history and registered outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= CLR_HOME;
      key_prev <= 1'b1;
      vx       <= '0;
      vy       <= '0;
      vc       <= '0;
      vp       <= 1'b0;
      hs_en    <= 1'b0;
      gm_en    <= 1'b0;
    end else begin
      state    <= state_nx;
      key_prev <= key_start;
      vx       <= x_d;
      vy       <= y_d;
      vc       <= col_d;
      vp       <= plot_d;
      hs_en    <= (state_nx == DRAW_HOME);
      gm_en    <= (state_nx == RUN);
    end
  end

  // Screen flow transitions
  always_comb begin
    state_nx = state;
    unique case (state)
      CLR_HOME:
        if (clr_done) state_nx = DRAW_HOME;
      DRAW_HOME:
        if (bus.hs_done) state_nx = HOME_IDLE;
      HOME_IDLE:
        if (key_rise) state_nx = CLR_GAME;
      CLR_GAME:
        if (clr_done) state_nx = RUN;
      RUN:
        if (game_over) state_nx = CLR_HOME;
      default:
        state_nx = CLR_HOME;
    endcase
  end

  // Pixel source select; idle holds position
  always_comb begin
    x_d    = vx;
    y_d    = vy;
    col_d  = vc;
    plot_d = 1'b0;
    unique case (state)
      CLR_HOME, CLR_GAME: begin
        x_d    = cx;
        y_d    = cy;
        col_d  = CLR_COL;
        plot_d = 1'b1;
      end
      DRAW_HOME: begin
        x_d    = bus.hs_x;
        y_d    = bus.hs_y;
        col_d  = bus.hs_col;
        plot_d = bus.hs_plot;
      end
      RUN: begin
        x_d    = bus.gm_x;
        y_d    = bus.gm_y;
        col_d  = bus.gm_col;
        plot_d = bus.gm_plot;
      end
      default: ;
    endcase
  end

  assign bus.vga_x      = vx;
  assign bus.vga_y      = vy;
  assign bus.vga_colour = vc;
  assign bus.vga_plot   = vp;
  assign bus.hs_enable  = hs_en;
  assign bus.gm_enable  = gm_en;
  assign state_o        = state;

endmodule

// File: tb/tb_screen_sequencer.sv
// tb_screen_sequencer: randomized drawer data
// against a pixel-index screen-flow model.
module tb_screen_sequencer;
  import screen_pkg::*;

  localparam int W    = 160;
  localparam int H    = 120;
  localparam int NPIX = W * H;

  logic       clk = 1'b0;
  logic       resetn;
  logic       key_start;
  logic       game_over;
  logic [2:0] state_o;

  screen_if bus ();

  screen_sequencer dut (
    .clk       (clk),
    .resetn    (resetn),
    .key_start (key_start),
    .game_over (game_over),
    .bus       (bus),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [23:0] sb[$];
  logic [23:0] mon_e;
  logic [23:0] mon_a;
  int          cyc = 0;

  int m_mode;
  int m_pix;
  bit m_kprev;
  int e_x;
  int e_y;
  int e_c;
  int e_p;
  bit fix_hs;
  int plots;

  function automatic logic [23:0] dut_vec();
    return {state_o, bus.hs_enable,
            bus.gm_enable, bus.vga_x,
            bus.vga_y, bus.vga_colour,
            bus.vga_plot};
  endfunction

  task automatic chk(string nm,
                     logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  // One clock: randomize drawers, predict, push
  task automatic step();
    int nm;
    if (!fix_hs) begin
      bus.hs_x    = 8'($urandom_range(0, W-1));
      bus.hs_y    = 7'($urandom_range(0, H-1));
      bus.hs_col  = 3'($urandom);
      bus.hs_plot = 1'($urandom);
    end
    bus.gm_x    = 8'($urandom_range(0, W-1));
    bus.gm_y    = 7'($urandom_range(0, H-1));
    bus.gm_col  = 3'($urandom);
    bus.gm_plot = 1'($urandom);
    if (!resetn) begin
      m_mode  = 0;
      m_pix   = 0;
      m_kprev = 1'b1;
      e_x = 0; e_y = 0; e_c = 0; e_p = 0;
    end else begin
      nm = m_mode;
      case (m_mode)
        0, 3: begin
          e_x = m_pix % W;
          e_y = m_pix / W;
          e_c = 0;
          e_p = 1;
          if (m_pix == NPIX - 1) begin
            m_pix = 0;
            nm = (m_mode == 0) ? 1 : 4;
          end else begin
            m_pix++;
          end
        end
        1: begin
          e_x = bus.hs_x;
          e_y = bus.hs_y;
          e_c = bus.hs_col;
          e_p = bus.hs_plot;
          if (bus.hs_done) nm = 2;
        end
        2: begin
          e_p = 0;
          if (key_start && !m_kprev) nm = 3;
        end
        default: begin
          e_x = bus.gm_x;
          e_y = bus.gm_y;
          e_c = bus.gm_col;
          e_p = bus.gm_plot;
          if (game_over) nm = 0;
        end
      endcase
      m_kprev = key_start;
      m_mode  = nm;
    end
    sb.push_back({3'(m_mode),
                  m_mode == 1, m_mode == 4,
                  8'(e_x), 7'(e_y),
                  3'(e_c), 1'(e_p)});
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compare each cycle
  always @(negedge clk) begin
    cyc++;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      mon_a = dut_vec();
      n_chk++;
      if (mon_a !== mon_e) begin
        n_fail++;
        $display("FAIL sb cyc %0d: got %h want %h",
                 cyc, mon_a, mon_e);
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn      = 1'b0;
    key_start   = 1'b1;
    game_over   = 1'b0;
    bus.hs_done = 1'b0;
    fix_hs      = 1'b0;
    repeat (3) step();
    chk("reset_state", 32'(state_o), 0);
    chk("reset_vga",
        32'({bus.vga_x, bus.vga_y,
             bus.vga_colour, bus.vga_plot}), 0);
    chk("reset_en",
        32'({bus.hs_enable, bus.gm_enable}), 0);

    resetn = 1'b1;
    plots  = 0;
    for (int i = 0; i < NPIX; i++) begin
      step();
      if (i == 0)
        chk("first_pixel",
            32'({bus.vga_x, bus.vga_y,
                 bus.vga_plot}), 32'd1);
      plots += int'(bus.vga_plot);
    end
    chk("clear_plots", 32'(plots), NPIX);
    chk("last_x", 32'(bus.vga_x), 159);
    chk("last_y", 32'(bus.vga_y), 119);
    chk("to_draw_home", 32'(state_o), 1);
    chk("hs_en_on", 32'(bus.hs_enable), 1);

    repeat (5) step();
    fix_hs      = 1'b1;
    bus.hs_x    = 8'd5;
    bus.hs_y    = 7'd7;
    bus.hs_col  = 3'b101;
    bus.hs_plot = 1'b1;
    step();
    chk("hs_pass_x", 32'(bus.vga_x), 5);
    chk("hs_pass_y", 32'(bus.vga_y), 7);
    chk("hs_pass_c", 32'(bus.vga_colour), 5);
    bus.hs_done = 1'b1;
    step();
    chk("hs_en_drop", 32'(bus.hs_enable), 0);
    chk("to_idle", 32'(state_o), 2);
    bus.hs_done = 1'b0;
    fix_hs      = 1'b0;

    repeat (10) step();
    chk("key_held", 32'(state_o), 2);
    chk("idle_noplot", 32'(bus.vga_plot), 0);
    game_over = 1'b1;
    step();
    game_over = 1'b0;
    repeat (3) step();
    chk("go_in_idle", 32'(state_o), 2);

    key_start = 1'b0;
    repeat ($urandom_range(2, 6)) step();
    key_start = 1'b1;
    step();
    chk("key_edge", 32'(state_o), 3);
    repeat (NPIX) step();
    chk("to_run", 32'(state_o), 4);
    chk("gm_en_on", 32'(bus.gm_enable), 1);
    chk("hs_en_off", 32'(bus.hs_enable), 0);

    repeat (40) begin
      key_start = 1'($urandom);
      step();
    end
    chk("key_in_run", 32'(state_o), 4);
    game_over = 1'b1;
    step();
    game_over = 1'b0;
    chk("gm_en_drop", 32'(bus.gm_enable), 0);
    chk("go_to_clr", 32'(state_o), 0);
    step();
    chk("restart_org",
        32'({bus.vga_x, bus.vga_y,
             bus.vga_plot}), 32'd1);

    repeat (10000) step();
    chk("pix10000_x", 32'(bus.vga_x), 80);
    chk("pix10000_y", 32'(bus.vga_y), 62);
    resetn = 1'b0;
    step();
    chk("midreset",
        32'(dut_vec()), 0);
    resetn = 1'b1;
    step();
    chk("post_rst_org",
        32'({bus.vga_x, bus.vga_y,
             bus.vga_plot}), 32'd1);
    repeat (NPIX - 1) step();
    chk("home_again", 32'(state_o), 1);

    @(negedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
